riscv_fetch_unit: RTL and testbench
===================================

Name: riscv_fetch_unit

Overview:
- Front-end fetch stage and producer side of the instruction queue.
- Generates 8-byte-aligned fetch requests to instruction memory and tracks up to DEPTH outstanding requests.
- Buffers in-order responses and pushes {pc, 64-bit bundle, slot-1 valid, per-slot unit usage} into the queue through its push/push_accept handshake.
- Handles backend redirects by squashing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned.
- DEPTH, 2, fetch buffer entries; also the maximum number of outstanding requests, counting killed ones.

Ports:
- clk  input  1  clock.
- srst_n  input  1  reset; asynchronous assert, active-low.
- redirect_valid  input  1  backend redirect/flush request.
- redirect_pc  input  32  new fetch target; bits [1:0] ignored.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  request address; bits [2:0] always 0.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  response valid; responses return in request order.
- imem_rdata  input  64  response bundle; [31:0] is the word at addr, [63:32] the word at addr+4.
- iq_push  output  1  bundle valid toward the queue.
- iq_pc  output  32  pc of the first valid instruction in the bundle.
- iq_inst  output  64  bundle; slot 0 in [31:0].
- iq_predict_valid  output  1  slot 1 valid.
- iq_unit_usage0  output  `UNIT_NUM  execution-unit usage of slot 0.
- iq_unit_usage1  output  `UNIT_NUM  execution-unit usage of slot 1.
- iq_push_accept  input  1  queue has space.

Behaviour:
- State:
  - fetch_pc
  - circular buffer of DEPTH entries {pc, data, filled}, with head/tail pointers and count alloc_cnt
  - kill_cnt, the number of in-flight responses to discard.
- Reset (async): fetch_pc = RESET_PC; alloc_cnt, kill_cnt and both pointers = 0; all filled = 0. Every output is 0 during reset, except imem_addr, which equals {RESET_PC[31:3],3'b000}.
- Request rules:
  - imem_req = !redirect_valid && (alloc_cnt + kill_cnt < DEPTH).
  - imem_addr = {fetch_pc[31:3],3'b000}; it is held stable while imem_req is high and imem_gnt is low.
- On imem_req && imem_gnt:
  - Allocate the tail entry with pc = fetch_pc and filled = 0; tail++.
  - fetch_pc <= {fetch_pc[31:3]+1, 3'b000}.
- On imem_rvalid:
  - If kill_cnt != 0: drop the data and decrement kill_cnt.
  - Otherwise write the data into the oldest unfilled entry and set its filled bit.
  - imem_rvalid with nothing outstanding is a protocol error: ignore it, no state change.
- Response latency is at least one cycle after grant. Data written on cycle N is pushable on cycle N+1.
- Queue push:
  - iq_push = head.filled && !redirect_valid; iq_pc = head.pc.
  - If head.pc[2] == 0: iq_inst = head.data.
  - If head.pc[2] == 1: iq_inst = {head.data[63:32], `INST_NOP}. The queue presents slot 0 as always valid, so the misaligned slot is filled with a NOP (32'h0000_0013).
  - iq_predict_valid = 1; there is no branch predictor in this revision.
  - Unit usage comes from a combinational predecode of iq_inst[31:0] and iq_inst[63:32].
  - iq_push && iq_push_accept: head++ and alloc_cnt--. Push and grant in the same cycle leave alloc_cnt unchanged.
- Redirect (highest priority, same cycle):
  - imem_req = 0 and iq_push = 0.
  - Clear the buffer: pointers = 0, alloc_cnt = 0, filled = 0.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - kill_cnt <= kill_cnt + unfilled_alloc - (imem_rvalid ? 1 : 0), where unfilled_alloc counts allocated entries not yet filled. A response arriving in the redirect cycle is dropped.
- Back-to-back redirects: each one restarts from its own redirect_pc, and kill_cnt accumulates correctly.
- Full buffer: no request is issued. Wrap-around is mod DEPTH; DEPTH must be a power of two ≥ 2.
- Async reset mid-operation: all state is discarded. Instruction memory is reset on the same net, so no stale responses arrive.

Decomposition:
- riscv_def.v gains:
  - `INST_NOP
  - the `UNIT_NUM unit bit indices (ALU, MUL, LSU, BRU, CSR)
  - the RV32 opcode constants used by predecode.
- One sub-module, riscv_predecode: combinational, 32-bit instruction in and `UNIT_NUM one-hot usage out. It is instantiated twice, once per slot.

Test Plan:
1. RESET_PC = 0x100; gnt tied 1; 1-cycle response latency; accept = 1 → requests to 0x100, 0x108, 0x110; pushes with pc 0x100, 0x108, 0x110 in order, each carrying the matching data.
2. DEPTH = 2, accept = 0 → imem_req drops after 2 grants. Raise accept → one push, then imem_req reasserts in the next cycle.
3. Redirect to 0x206 → imem_addr = 0x200; pushed pc = 0x204; iq_inst[31:0] = 0x00000013 and [63:32] = data[63:32]; next request goes to 0x208.
4. Two requests in flight, redirect to 0x400 → the next 2 rvalid produce no push; the first push has pc 0x400.
5. Redirect in the same cycle as rvalid with a filled head → no push that cycle; kill_cnt = outstanding - 1; the buffer is empty the following cycle.
6. Assert srst_n low while requests are outstanding and buffered → outputs go to 0 immediately without a clock edge; after release, first request is to RESET_PC.

Source files
------------

// File: rtl/riscv_fetch_unit_pkg.sv
// Shared constants for the fetch front end: unit indices, the NOP encoding,
// RV32 major opcodes used by predecode, and the fetch-block alignment helper.
`timescale 1ns/1ps
package riscv_fetch_unit_pkg;

    localparam int UNIT_NUM = 5;
    localparam int UNIT_ALU = 0;
    localparam int UNIT_MUL = 1;
    localparam int UNIT_LSU = 2;
    localparam int UNIT_BRU = 3;
    localparam int UNIT_CSR = 4;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    function automatic logic [31:0] align8(input logic [31:0] a);
        return {a[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/riscv_fetch_unit_predecode.sv
// Combinational predecode: maps one RV32 instruction to a one-hot
// execution-unit usage vector (all zero for unrecognised opcodes).
`timescale 1ns/1ps
module riscv_predecode
    import riscv_fetch_unit_pkg::*;
(
    input  logic [31:0]         i_inst,
    output logic [UNIT_NUM-1:0] o_unit_usage
);

    logic w_unused_bits;
    assign w_unused_bits = ^i_inst[24:7];

    always_comb begin
        o_unit_usage = '0;
        case (i_inst[6:0])
            OPC_LUI, OPC_AUIPC, OPC_OP_IMM: o_unit_usage[UNIT_ALU] = 1'b1;
            OPC_OP: begin
                // M-extension ops share the OP major opcode; funct7 separates them
                if (i_inst[31:25] == FUNCT7_MULDIV) begin
                    o_unit_usage[UNIT_MUL] = 1'b1;
                end else begin
                    o_unit_usage[UNIT_ALU] = 1'b1;
                end
            end
            OPC_JAL, OPC_JALR, OPC_BRANCH:      o_unit_usage[UNIT_BRU] = 1'b1;
            OPC_LOAD, OPC_STORE, OPC_MISC_MEM:  o_unit_usage[UNIT_LSU] = 1'b1;
            OPC_SYSTEM:                         o_unit_usage[UNIT_CSR] = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Fetch stage: issues 8-byte-aligned imem requests, buffers in-order
// responses in a DEPTH-entry ring and pushes predecoded bundles to the IQ.
`timescale 1ns/1ps
module riscv_fetch_unit
    import riscv_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
)(
    input  logic                clk,
    input  logic                srst_n,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [63:0]         imem_rdata,
    output logic                iq_push,
    output logic [31:0]         iq_pc,
    output logic [63:0]         iq_inst,
    output logic                iq_predict_valid,
    output logic [UNIT_NUM-1:0] iq_unit_usage0,
    output logic [UNIT_NUM-1:0] iq_unit_usage1,
    input  logic                iq_push_accept
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_pc   [DEPTH];
    logic [63:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_filled;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W-1:0] r_fill_ptr;
    logic [CNT_W-1:0] r_alloc_cnt;
    logic [CNT_W-1:0] r_kill_cnt;

    logic [CNT_W-1:0] w_filled_cnt;
    logic [CNT_W-1:0] w_unfilled;
    logic [CNT_W:0]   w_inflight;
    logic             w_grant;
    logic             w_pop;
    logic             w_rsp_kill;
    logic             w_rsp_fill;
    logic [31:0]      w_head_pc;
    logic [63:0]      w_head_data;
    logic             w_unused_bits;

    assign w_unused_bits = ^redirect_pc[1:0];

    always_comb begin
        w_filled_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_filled_cnt = w_filled_cnt + CNT_W'(r_filled[i]);
        end
    end

    // Unfilled entries are always the youngest allocations, so this is also
    // the number of live (non-killed) responses still owed by imem.
    assign w_unfilled = r_alloc_cnt - w_filled_cnt;
    assign w_inflight = {1'b0, r_alloc_cnt} + {1'b0, r_kill_cnt};

    assign imem_req  = srst_n && !redirect_valid && (w_inflight < (CNT_W + 1)'(DEPTH));
    assign imem_addr = align8(r_fetch_pc);
    assign w_grant   = imem_req && imem_gnt;

    assign w_rsp_kill = imem_rvalid && (r_kill_cnt != '0);
    assign w_rsp_fill = imem_rvalid && (r_kill_cnt == '0) && (w_unfilled != '0);

    assign w_head_pc   = r_pc[r_head];
    assign w_head_data = r_data[r_head];

    assign iq_push          = r_filled[r_head] && !redirect_valid;
    assign iq_pc            = w_head_pc;
    assign iq_inst          = w_head_pc[2] ? {w_head_data[63:32], INST_NOP} : w_head_data;
    assign iq_predict_valid = srst_n;
    assign w_pop            = iq_push && iq_push_accept;

    riscv_predecode u_predecode0 (
        .i_inst       (iq_inst[31:0]),
        .o_unit_usage (iq_unit_usage0)
    );

    riscv_predecode u_predecode1 (
        .i_inst       (iq_inst[63:32]),
        .o_unit_usage (iq_unit_usage1)
    );

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_fetch_pc  <= RESET_PC;
            r_filled    <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_fill_ptr  <= '0;
            r_alloc_cnt <= '0;
            r_kill_cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_data[i] <= '0;
            end
        end else if (redirect_valid) begin
            r_fetch_pc  <= {redirect_pc[31:2], 2'b00};
            r_filled    <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_fill_ptr  <= '0;
            r_alloc_cnt <= '0;
            // A response landing this cycle settles one of the owed responses
            r_kill_cnt  <= r_kill_cnt + w_unfilled - CNT_W'(w_rsp_kill || w_rsp_fill);
        end else begin
            if (w_grant) begin
                r_pc[r_tail]     <= r_fetch_pc;
                r_filled[r_tail] <= 1'b0;
                r_tail           <= r_tail + PTR_W'(1);
                r_fetch_pc       <= {r_fetch_pc[31:3] + 29'd1, 3'b000};
            end
            if (w_rsp_kill) begin
                r_kill_cnt <= r_kill_cnt - CNT_W'(1);
            end
            if (w_rsp_fill) begin
                r_data[r_fill_ptr]   <= imem_rdata;
                r_filled[r_fill_ptr] <= 1'b1;
                r_fill_ptr           <= r_fill_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_filled[r_head] <= 1'b0;
                r_head           <= r_head + PTR_W'(1);
            end
            r_alloc_cnt <= r_alloc_cnt + CNT_W'(w_grant) - CNT_W'(w_pop);
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Scoreboard bench for riscv_fetch_unit: directed fetch, backpressure,
// redirect, kill and async-reset scenarios against a simple imem model.
`timescale 1ns/1ps
module tb_riscv_fetch_unit;
    import riscv_fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct packed {
        logic [31:0]         pc;
        logic [63:0]         inst;
        logic [UNIT_NUM-1:0] u0;
        logic [UNIT_NUM-1:0] u1;
    } push_t;

    logic                clk;
    logic                srst_n;
    logic                redirect_valid;
    logic [31:0]         redirect_pc;
    logic                imem_req;
    logic [31:0]         imem_addr;
    logic                imem_gnt;
    logic                imem_rvalid;
    logic [63:0]         imem_rdata;
    logic                iq_push;
    logic [31:0]         iq_pc;
    logic [63:0]         iq_inst;
    logic                iq_predict_valid;
    logic [UNIT_NUM-1:0] iq_unit_usage0;
    logic [UNIT_NUM-1:0] iq_unit_usage1;
    logic                iq_push_accept;

    push_t       exp_push [$];
    logic [31:0] exp_req  [$];
    logic [31:0] pending  [$];
    push_t       mon_e;
    logic [31:0] bus_a;
    logic [31:0] bus_exp;
    logic        mem_hold;
    int          checks;
    int          errors;
    int          grant_cnt;

    riscv_fetch_unit #(
        .RESET_PC (RST_PC),
        .DEPTH    (2)
    ) dut (
        .clk              (clk),
        .srst_n           (srst_n),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .iq_push          (iq_push),
        .iq_pc            (iq_pc),
        .iq_inst          (iq_inst),
        .iq_predict_valid (iq_predict_valid),
        .iq_unit_usage0   (iq_unit_usage0),
        .iq_unit_usage1   (iq_unit_usage1),
        .iq_push_accept   (iq_push_accept)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a table of real encodings indexed by
    // word-in-32B, with the rd/imm field perturbed by address for uniqueness.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        case (a[4:2])
            3'd0:    w = 32'h00A0_0093; // addi
            3'd1:    w = 32'h0220_81B3; // mul
            3'd2:    w = 32'h0000_A103; // lw
            3'd3:    w = 32'h0020_8463; // beq
            3'd4:    w = 32'h3000_2573; // csrrs
            3'd5:    w = 32'h0020_81B3; // add
            3'd6:    w = 32'h0000_006F; // jal
            default: w = 32'h0000_0037; // lui
        endcase
        return w ^ {20'h0, a[9:5], 7'h0};
    endfunction

    function automatic logic [UNIT_NUM-1:0] unit_of(input logic [2:0] idx);
        case (idx)
            3'd0:    return 5'b00001;
            3'd1:    return 5'b00010;
            3'd2:    return 5'b00100;
            3'd3:    return 5'b01000;
            3'd4:    return 5'b10000;
            3'd5:    return 5'b00001;
            3'd6:    return 5'b01000;
            default: return 5'b00001;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_push(input logic [31:0] pc);
        push_t       e;
        logic [31:0] base;
        logic [31:0] base4;
        base  = {pc[31:3], 3'b000};
        base4 = base + 32'd4;
        e.pc  = pc;
        if (pc[2]) begin
            e.inst = {mem_word(base4), INST_NOP};
            e.u0   = 5'b00001;
        end else begin
            e.inst = {mem_word(base4), mem_word(base)};
            e.u0   = unit_of(base[4:2]);
        end
        e.u1 = unit_of(base4[4:2]);
        exp_push.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int target);
        int n;
        n = 0;
        while (grant_cnt < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (grant_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got %0d grants, required %0d", grant_cnt, target);
        end
        #1;
        imem_gnt = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_push.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (exp_push.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pushes outstanding, required 0", exp_push.size());
        end
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_req",   64'(imem_req), 64'd0);
        check("rst_addr",  64'(imem_addr), 64'(RST_PC));
        check("rst_push",  64'(iq_push), 64'd0);
        check("rst_pc",    64'(iq_pc), 64'd0);
        check("rst_inst",  iq_inst, 64'd0);
        check("rst_pv",    64'(iq_predict_valid), 64'd0);
        check("rst_u0",    64'(iq_unit_usage0), 64'd0);
        check("rst_u1",    64'(iq_unit_usage1), 64'd0);
    endtask

    // imem model: grants observed at negedge, responses driven in order with
    // one cycle minimum latency unless held.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (srst_n && imem_req && imem_gnt) begin
                grant_cnt++;
                if (exp_req.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected: got request to %h, required none", imem_addr);
                end else begin
                    bus_exp = exp_req.pop_front();
                    check("req_addr", 64'(imem_addr), 64'(bus_exp));
                end
                pending.push_back(imem_addr);
            end
            @(posedge clk);
            #2;
            if (!srst_n) pending.delete();
            if (srst_n && !mem_hold && pending.size() > 0) begin
                bus_a       = pending.pop_front();
                imem_rvalid = 1'b1;
                imem_rdata  = {mem_word(bus_a + 32'd4), mem_word(bus_a)};
            end else begin
                imem_rvalid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (srst_n && iq_push && iq_push_accept) begin
            if (exp_push.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL push_unexpected: got push pc %h, required none", iq_pc);
            end else begin
                mon_e = exp_push.pop_front();
                check("push_pc",   64'(iq_pc), 64'(mon_e.pc));
                check("push_inst", iq_inst, mon_e.inst);
                check("push_u0",   64'(iq_unit_usage0), 64'(mon_e.u0));
                check("push_u1",   64'(iq_unit_usage1), 64'(mon_e.u1));
                check("push_pv",   64'(iq_predict_valid), 64'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        checks         = 0;
        errors         = 0;
        grant_cnt      = 0;
        mem_hold       = 1'b0;
        srst_n         = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        iq_push_accept = 1'b0;

        #2 srst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (3) @(posedge clk);
        #1 srst_n = 1'b1;

        // Sequential fetch with tied grant and immediate accept
        exp_req.push_back(32'h100);
        exp_req.push_back(32'h108);
        exp_req.push_back(32'h110);
        expect_push(32'h100);
        expect_push(32'h108);
        expect_push(32'h110);
        tick();
        iq_push_accept = 1'b1;
        imem_gnt       = 1'b1;
        wait_grants(3);
        wait_drain();

        // Backpressure: buffer fills, requests stop until one push drains
        iq_push_accept = 1'b0;
        exp_req.push_back(32'h118);
        exp_req.push_back(32'h120);
        imem_gnt = 1'b1;
        wait_grants(5);
        repeat (3) @(negedge clk);
        check("req_full",   64'(imem_req), 64'd0);
        check("push_held",  64'(iq_push), 64'd1);
        tick();
        expect_push(32'h118);
        iq_push_accept = 1'b1;
        @(negedge clk);
        check("req_before_pop", 64'(imem_req), 64'd0);
        tick();
        iq_push_accept = 1'b0;
        @(negedge clk);
        check("req_reassert", 64'(imem_req), 64'd1);
        tick();
        expect_push(32'h120);
        iq_push_accept = 1'b1;
        wait_drain();

        // Redirect into the upper half of a fetch block
        redirect_valid = 1'b1;
        redirect_pc    = 32'h206;
        @(negedge clk);
        check("req_redirect", 64'(imem_req), 64'd0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("addr_redirect", 64'(imem_addr), 64'h200);
        exp_req.push_back(32'h200);
        exp_req.push_back(32'h208);
        expect_push(32'h204);
        expect_push(32'h208);
        tick();
        imem_gnt = 1'b1;
        wait_grants(7);
        wait_drain();

        // Two in-flight fetches killed by a redirect
        mem_hold = 1'b1;
        exp_req.push_back(32'h210);
        exp_req.push_back(32'h218);
        imem_gnt = 1'b1;
        wait_grants(9);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        @(negedge clk);
        check("req_redirect2", 64'(imem_req), 64'd0);
        tick();
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        @(negedge clk);
        check("req_kill_wait", 64'(imem_req), 64'd0);
        exp_req.push_back(32'h400);
        expect_push(32'h400);
        tick();
        imem_gnt = 1'b1;
        wait_grants(10);
        wait_drain();

        // Redirect coinciding with a response while the head is filled
        mem_hold       = 1'b1;
        iq_push_accept = 1'b0;
        exp_req.push_back(32'h408);
        exp_req.push_back(32'h410);
        imem_gnt = 1'b1;
        wait_grants(12);
        tick();
        mem_hold = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        iq_push_accept = 1'b1;
        @(negedge clk);
        check("head_pc_filled",   64'(iq_pc), 64'h408);
        check("push_redir_fill",  64'(iq_push), 64'd0);
        check("rvalid_in_redir",  64'(imem_rvalid), 64'd1);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("buf_empty",        64'(iq_push), 64'd0);
        check("req_after_redir",  64'(imem_req), 64'd1);
        exp_req.push_back(32'h500);
        expect_push(32'h500);
        tick();
        imem_gnt = 1'b1;
        wait_grants(13);
        wait_drain();

        // Async reset with one buffered and one outstanding fetch
        mem_hold       = 1'b1;
        iq_push_accept = 1'b0;
        exp_req.push_back(32'h508);
        exp_req.push_back(32'h510);
        imem_gnt = 1'b1;
        wait_grants(15);
        tick();
        mem_hold = 1'b0;
        tick();
        mem_hold = 1'b1;
        @(negedge clk);
        check("push_pre_rst", 64'(iq_push), 64'd1);
        #2 srst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        srst_n         = 1'b1;
        mem_hold       = 1'b0;
        iq_push_accept = 1'b1;
        exp_req.push_back(32'h100);
        expect_push(32'h100);
        imem_gnt = 1'b1;
        wait_grants(16);
        wait_drain();

        repeat (3) @(posedge clk);
        check("req_queue_empty", 64'(exp_req.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
